// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: reads the framebuffer RAM in raster order and turns it
// into a valid/ready pixel stream. A small prefetch FIFO absorbs downstream
// stalls, and a credit check on read issue keeps that FIFO from overflowing.
module fb_scanout_reader #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    input  logic [31:0]       mem_readdata,
    output logic [23:0]       px_data,
    output logic              px_sof,
    output logic              px_eol,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              underflow,
    output logic              busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   restart;

    // read-side raster position and linear address
    logic [XW-1:0]     x_rd;
    logic [YW-1:0]     y_rd;
    logic [ADDR_W-1:0] addr;

    // one read can be in flight; its tags travel alongside it
    logic inflight;
    logic cap_sof;
    logic cap_eol;

    // prefetch FIFO entry: {sof, eol, rgb}
    logic [25:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [25:0]   head;

    // output-side frame tracking
    logic [YW-1:0] y_out;
    logic          in_frame;
    logic          last_done;
    logic          underflow_q;

    logic issue;
    logic rd_last;
    logic push;
    logic pop;
    logic pop_last;
    logic fifo_empty;

    // the upper byte of the stored word is not part of the pixel
    logic unused_rd_hi;
    assign unused_rd_hi = ^mem_readdata[31:24];

    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign rd_last    = (x_rd == X_LAST) && (y_rd == Y_LAST);

    // credit counts the in-flight read so a full FIFO never sees a push
    assign issue    = (state == RUN) &&
                      (({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(FIFO_DEPTH));
    assign push     = inflight;
    assign pop      = px_valid && px_ready;
    assign pop_last = pop && head[24] && (y_out == Y_LAST);

    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_clken      = ~reset;

    assign px_valid  = ~fifo_empty;
    assign px_data   = px_valid ? head[23:0] : 24'd0;
    assign px_eol    = px_valid & head[24];
    assign px_sof    = px_valid & head[25];
    assign busy      = (state != IDLE);
    assign underflow = underflow_q;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state; restart marks every entry into RUN so counters start clean
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    restart   = 1'b1;
                end
            end
            RUN: begin
                if (issue && rd_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !inflight && last_done) begin
                    if (enable) begin
                        state_nxt = RUN;
                        restart   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // read-side raster walk; address is linear across lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_rd <= '0;
            y_rd <= '0;
            addr <= ADDR_W'(BASE_ADDR);
        end else if (restart) begin
            x_rd <= '0;
            y_rd <= '0;
            addr <= ADDR_W'(BASE_ADDR);
        end else if (issue) begin
            addr <= addr + 1'b1;
            if (x_rd == X_LAST) begin
                x_rd <= '0;
                y_rd <= (y_rd == Y_LAST) ? '0 : y_rd + 1'b1;
            end else begin
                x_rd <= x_rd + 1'b1;
            end
        end
    end

    // delay issue and its coordinate tags to line up with the RAM data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            cap_sof  <= 1'b0;
            cap_eol  <= 1'b0;
        end else begin
            inflight <= issue;
            cap_sof  <= issue && (x_rd == '0) && (y_rd == '0);
            cap_eol  <= issue && (x_rd == X_LAST);
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cap_sof, cap_eol, mem_readdata[23:0]};
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // output-side frame position: line count, mid-frame flag, frame-done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out     <= '0;
            in_frame  <= 1'b0;
            last_done <= 1'b0;
        end else begin
            if (restart) begin
                y_out     <= '0;
                last_done <= 1'b0;
            end else begin
                if (pop && head[24]) y_out <= (y_out == Y_LAST) ? '0 : y_out + 1'b1;
                if (pop_last)        last_done <= 1'b1;
            end
            if (pop_last)              in_frame <= 1'b0;
            else if (pop && head[25])  in_frame <= 1'b1;
        end
    end

    // sticky underflow: consumer ready but nothing to give, mid-frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) underflow_q <= 1'b0;
        else if ((state != IDLE) && in_frame && px_ready && !px_valid) underflow_q <= 1'b1;
    end

    // the credit rule must make a push into a full FIFO impossible
    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: RAM model, stream/occupancy reference model
// checked every cycle, plus directed scenarios and a randomized phase.
module tb_fb_scanout_reader;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int NPIX  = H * V;
    localparam int BASE  = 'h100;
    localparam int AW    = 17;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_clken;
    logic          mem_write;
    logic [31:0]   mem_readdata;
    logic [23:0]   px_data;
    logic          px_sof;
    logic          px_eol;
    logic          px_valid;
    logic          px_ready;
    logic          underflow;
    logic          busy;

    fb_scanout_reader #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BASE_ADDR(BASE), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write), .mem_readdata(mem_readdata),
        .px_data(px_data), .px_sof(px_sof), .px_eol(px_eol),
        .px_valid(px_valid), .px_ready(px_ready),
        .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // framebuffer RAM: word i = {EE, (i*7)[7:0], i[15:0]}, one-cycle read
    logic [31:0] ram [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = {8'hEE, 8'(i * 7), 16'(i)};
    end
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address[9:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state: pops, issues, captures, last-popped pixel
    int          k = 0, iss = 0, cap = 0, cs_count = 0, sof_cnt = 0;
    bit          p1 = 0, p2 = 0, stall_prev = 0, exp_uf = 0;
    logic [23:0] prev_data, last_data;
    logic        prev_sof, prev_eol, last_sof, last_eol;

    // per-cycle compare against the stream model
    always @(negedge clk) begin
        int occ, f;
        if (reset) begin
            k = 0; iss = 0; cap = 0; p1 = 0; p2 = 0;
            stall_prev = 0; exp_uf = 0;
        end else begin
            cap += int'(p2);
            occ = cap - k;
            chk("valid_vs_occupancy", 32'(px_valid), 32'(occ > 0));
            chk("occupancy_bound", 32'(occ <= DEPTH), 32'd1);
            chk("underflow", 32'(underflow), 32'(exp_uf));
            chk("mem_write", 32'(mem_write), 32'd0);
            chk("mem_clken", 32'(mem_clken), 32'd1);
            if (!busy) chk("idle_quiet", {30'd0, px_valid, mem_chipselect}, 32'd0);
            if (mem_chipselect) begin
                chk("rd_addr", 32'(mem_address), 32'(BASE + iss % NPIX));
                chk("credit", 32'((occ + int'(p1)) < DEPTH), 32'd1);
                iss++;
                cs_count++;
            end
            if (stall_prev)
                chk("stall_hold", {5'd0, px_valid, px_sof, px_eol, px_data},
                    {5'd0, 1'b1, prev_sof, prev_eol, prev_data});
            if (px_valid && px_ready) begin
                f = k % NPIX;
                chk("px_data", 32'(px_data), 32'(ram[BASE + f][23:0]));
                chk("px_sof", 32'(px_sof), 32'(f == 0));
                chk("px_eol", 32'(px_eol), 32'(f % H == H - 1));
                last_data = px_data; last_sof = px_sof; last_eol = px_eol;
                if (px_sof) sof_cnt++;
                k++;
            end
            if (px_ready && !px_valid && (k % NPIX) != 0) exp_uf = 1;
            stall_prev = px_valid && !px_ready;
            prev_data = px_data; prev_sof = px_sof; prev_eol = px_eol;
            p2 = p1;
            p1 = mem_chipselect;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_pops(input string name, input int target);
        int n = 0;
        while (k < target && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(k >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k0, lat, cs0, s0;
        reset = 1'b1; enable = 1'b0; px_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd0);
        chk("rst_data", {px_sof, px_eol, px_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // A: one-cycle enable pulse, ready held high
        k0 = k; px_ready = 1'b1; enable = 1'b1;
        step(); enable = 1'b0; lat = 1;
        while (!px_valid && lat < 20) begin step(); lat++; end
        chk("A_latency", 32'(lat), 32'd3);
        wait_idle("A_idle");
        chk("A_count", 32'(k - k0), 32'd8);
        chk("A_last_data", 32'(last_data), 32'h310107);
        chk("A_last_eol", 32'(last_eol), 32'd1);
        chk("A_underflow", 32'(underflow), 32'd0);

        // B: ready pattern 1,0,0,1 repeated
        k0 = k; enable = 1'b1;
        step(); enable = 1'b0;
        for (int i = 0; i < 400 && busy; i++) begin
            px_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        px_ready = 1'b1;
        wait_idle("B_idle");
        chk("B_count", 32'(k - k0), 32'd8);
        chk("B_underflow", 32'(underflow), 32'd0);

        // C: enable held for three frames
        k0 = k; s0 = sof_cnt; enable = 1'b1;
        wait_pops("C_progress", k0 + 17);
        enable = 1'b0;
        wait_idle("C_idle");
        chk("C_count", 32'(k - k0), 32'd24);
        chk("C_sof_count", 32'(sof_cnt - s0), 32'd3);

        // D: enable drops after pixel 2; frame still completes, then quiet
        k0 = k; enable = 1'b1;
        wait_pops("D_progress", k0 + 3);
        enable = 1'b0;
        wait_idle("D_idle");
        chk("D_count", 32'(k - k0), 32'd8);
        cs0 = cs_count;
        repeat (20) step();
        chk("D_no_reads", 32'(cs_count - cs0), 32'd0);

        // E: consumer stalled 20 cycles; credit limits reads to FIFO depth
        k0 = k; cs0 = cs_count; px_ready = 1'b0; enable = 1'b1;
        step(); enable = 1'b0;
        repeat (20) step();
        chk("E_reads", 32'(cs_count - cs0), 32'(DEPTH));
        chk("E_valid", 32'(px_valid), 32'd1);
        px_ready = 1'b1;
        wait_idle("E_idle");
        chk("E_count", 32'(k - k0), 32'd8);
        chk("E_underflow", 32'(underflow), 32'd0);

        // F: async reset with a full FIFO, then restart
        px_ready = 1'b0; enable = 1'b1;
        repeat (10) step();
        chk("F_prefull", 32'(px_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("F_rst_valid", 32'(px_valid), 32'd0);
        chk("F_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; enable = 1'b1; px_ready = 1'b1;
        wait_pops("F_first", 1);
        chk("F_first_data", 32'(last_data), 32'h000100);
        chk("F_first_sof", 32'(last_sof), 32'd1);
        enable = 1'b0;
        wait_idle("F_idle");
        chk("F_count", 32'(k), 32'd8);

        // R: random ready and enable
        for (int i = 0; i < 600; i++) begin
            px_ready = ($urandom_range(9) < 7);
            if ($urandom_range(39) == 0) enable = ~enable;
            step();
        end
        enable = 1'b0; px_ready = 1'b1;
        wait_idle("R_idle");
        chk("R_whole_frames", 32'(k % NPIX), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
